car_sensor_gen: RTL

//  Generates the two photo-sensor waveforms (a, b) produced by one car passing the lot gate.
//  It is the transmitter counterpart to the occupancy counter's sensor decoder and drives

---
 rtl/parking_pkg.sv | 44 ++++
 rtl/car_sensor_gen_timer.sv | 28 ++
 rtl/car_sensor_gen.sv | 138 +++++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// Shared definitions for the car sensor generator and the occupancy decoder:
// phase state encoding, per-direction a/b patterns and direction constants.
package parking_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_S1   = 2'd1,
    ST_S2   = 2'd2,
    ST_S3   = 2'd3
  } state_e;

  localparam logic DIR_ENTER = 1'b1;
  localparam logic DIR_EXIT  = 1'b0;

  // Patterns are {a, b}
  localparam logic [1:0] ENTER_S1 = 2'b10;
  localparam logic [1:0] ENTER_S2 = 2'b11;
  localparam logic [1:0] ENTER_S3 = 2'b01;
  localparam logic [1:0] EXIT_S1  = 2'b01;
  localparam logic [1:0] EXIT_S2  = 2'b11;
  localparam logic [1:0] EXIT_S3  = 2'b10;

  function automatic logic [1:0] phase_pattern(input state_e s, input logic d);
    logic [1:0] p;
    case (s)
      ST_S1:   p = (d == DIR_ENTER) ? ENTER_S1 : EXIT_S1;
      ST_S2:   p = (d == DIR_ENTER) ? ENTER_S2 : EXIT_S2;
      ST_S3:   p = (d == DIR_ENTER) ? ENTER_S3 : EXIT_S3;
      default: p = 2'b00;
    endcase
    return p;
  endfunction

  function automatic state_e next_phase(input state_e s);
    state_e n;
    case (s)
      ST_S1:   n = ST_S2;
      ST_S2:   n = ST_S3;
      default: n = ST_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/car_sensor_gen_timer.sv
// Loadable phase down-counter. expire_o is high during the last cycle of a
// phase (count == 1); the count then idles at zero until the next load.
module sensor_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;

  // Reload on phase entry, otherwise count down and stop at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/car_sensor_gen.sv
// Car pass waveform generator: plays one enter or exit a/b sequence per start.
// Optional contact chatter on each edge is enabled with SENSOR_BOUNCE_EN.
//
//   state   | meaning
//   IDLE    | ab=00, waiting for start
//   S1      | first sensor blocked
//   S2      | both sensors blocked
//   S3      | second sensor blocked only
module car_sensor_gen
  import parking_pkg::*;
#(
  parameter int CNT_W = 8
`ifdef SENSOR_BOUNCE_EN
  ,
  parameter int BOUNCE_CYCLES = 4
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] hold,
  input  logic             abort,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  logic             dir_q;
  logic [CNT_W-1:0] hold_q;
  logic [1:0]       pat_q;
  logic             busy_q;
  logic             done_q;

  logic             start_acc;
  logic             kill;
  logic             step;
  state_e           nxt_state;
  logic [1:0]       nxt_pat;
  logic [CNT_W-1:0] hold_eff;
  logic             tmr_expire;

  assign hold_eff  = (hold == '0) ? CNT_W'(1) : hold;
  assign start_acc = (state_q == ST_IDLE) && start && !abort;
  assign kill      = (state_q != ST_IDLE) && abort;

  // Decide whether this edge moves to a new phase, and its pattern
  always_comb begin
    step      = 1'b0;
    nxt_state = state_q;
    nxt_pat   = 2'b00;
    if (start_acc) begin
      step      = 1'b1;
      nxt_state = ST_S1;
      nxt_pat   = phase_pattern(ST_S1, dir);
    end else if (state_q != ST_IDLE && !abort && tmr_expire) begin
      step      = 1'b1;
      nxt_state = next_phase(state_q);
      nxt_pat   = phase_pattern(nxt_state, dir_q);
    end
  end

  sensor_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (step),
    .load_val_i (start_acc ? hold_eff : hold_q),
    .expire_o   (tmr_expire)
  );

  // Sequencer FSM with registered pattern, busy and done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      hold_q  <= '0;
      pat_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (kill) begin
        state_q <= ST_IDLE;
        pat_q   <= 2'b00;
        busy_q  <= 1'b0;
      end else if (step) begin
        state_q <= nxt_state;
        pat_q   <= nxt_pat;
        busy_q  <= (nxt_state != ST_IDLE);
        done_q  <= (nxt_state == ST_IDLE);
        if (start_acc) begin
          dir_q  <= dir;
          hold_q <= hold_eff;
        end
      end
    end
  end

`ifdef SENSOR_BOUNCE_EN
  localparam int BW = $clog2(BOUNCE_CYCLES + 1);

  logic [BW-1:0] bnc_q;
  logic [1:0]    chg_q;
  logic [1:0]    out_q;

  // Chatter the changing output against the clean pattern; abort goes straight to 00
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bnc_q <= '0;
      chg_q <= 2'b00;
      out_q <= 2'b00;
    end else if (kill) begin
      bnc_q <= '0;
      chg_q <= 2'b00;
      out_q <= 2'b00;
    end else if (step) begin
      out_q <= nxt_pat;
      chg_q <= nxt_pat ^ pat_q;
      bnc_q <= (nxt_pat != pat_q) ? BW'(BOUNCE_CYCLES) : '0;
    end else if (bnc_q != '0) begin
      bnc_q <= bnc_q - 1'b1;
      out_q <= (bnc_q == BW'(1)) ? pat_q : (out_q ^ chg_q);
    end
  end

  assign a = out_q[1];
  assign b = out_q[0];
`else
  assign a = pat_q[1];
  assign b = pat_q[0];
`endif

  assign busy = busy_q;
  assign done = done_q;

endmodule
